// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters and a
// non-speculative return-address stack, looked up combinationally every fetch.
module branch_target_predictor #(
    parameter int ENTRIES   = 16,
    parameter int COUNTER_W = 2,
    parameter int RAS_DEPTH = 4,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int TAG_W    = 30 - IDX_W,
    localparam int CNT_W    = $clog2(RAS_DEPTH) + 1,
    localparam int PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      if_pc,
    output logic             pr_taken,
    output logic [31:0]      pr_target,
    input  logic             up_valid,
    input  logic [31:0]      up_pc,
    input  logic [1:0]       up_kind,
    input  logic             up_taken,
    input  logic [31:0]      up_target,
    input  logic             inv_all,
    output logic [CNT_W-1:0] ras_count
);

    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_JMP  = 2'd1,
        KIND_CALL = 2'd2,
        KIND_RET  = 2'd3
    } kind_t;

    localparam logic [COUNTER_W-1:0] CTR_WEAK = COUNTER_W'(1) << (COUNTER_W - 1);
    localparam logic [COUNTER_W-1:0] CTR_MAX  = '1;

    logic [ENTRIES-1:0]   valid;
    logic [TAG_W-1:0]     tag_mem    [ENTRIES];
    logic [31:0]          target_mem [ENTRIES];
    kind_t                kind_mem   [ENTRIES];
    logic [COUNTER_W-1:0] ctr_mem    [ENTRIES];

    logic [31:0]          ras_mem    [RAS_DEPTH];
    logic [PTR_W-1:0]     ras_ptr;
    logic [CNT_W-1:0]     ras_cnt;

    logic [IDX_W-1:0]     rd_idx, up_idx;
    logic [TAG_W-1:0]     rd_tag, up_tag;
    logic [PTR_W-1:0]     ptr_inc, ptr_dec;
    logic                 rd_hit, up_hit, do_upd, eff_taken, is_br;
    logic                 alloc, wr_target, wr_kind, ras_push, ras_pop;
    logic                 ras_full, ras_empty;
    logic [COUNTER_W-1:0] ctr_next;
    logic [31:0]          ras_top;

    // Instruction addresses are word aligned, so the two low PC bits carry no information.
    wire unused_pc_bits = ^{if_pc[1:0], up_pc[1:0]};

    assign rd_idx    = if_pc[IDX_W+1:2];
    assign rd_tag    = if_pc[31:IDX_W+2];
    assign up_idx    = up_pc[IDX_W+1:2];
    assign up_tag    = up_pc[31:IDX_W+2];
    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign up_hit    = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    // ras_ptr is the next free slot; the top of stack sits one below it, wrapping.
    assign ptr_inc   = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
    assign ptr_dec   = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
    assign ras_top   = ras_mem[ptr_dec];
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign ras_count = ras_cnt;

    always_comb begin
        do_upd    = up_valid && !inv_all && !RST;
        is_br     = (up_kind == KIND_BR);
        eff_taken = !is_br || up_taken;
        alloc     = do_upd && !up_hit && eff_taken;
        wr_target = do_upd && eff_taken;
        wr_kind   = do_upd && (up_hit || eff_taken);
        ras_push  = do_upd && (up_kind == KIND_CALL);
        ras_pop   = do_upd && (up_kind == KIND_RET) && !ras_empty;
        ctr_next  = ctr_mem[up_idx];
        if (up_taken) begin
            if (ctr_mem[up_idx] != CTR_MAX)
                ctr_next = ctr_mem[up_idx] + COUNTER_W'(1);
        end else begin
            if (ctr_mem[up_idx] != '0)
                ctr_next = ctr_mem[up_idx] - COUNTER_W'(1);
        end
    end

    always_comb begin
        pr_taken  = 1'b0;
        pr_target = 32'd0;
        if (rd_hit) begin
            case (kind_mem[rd_idx])
                KIND_BR: begin
                    pr_taken  = ctr_mem[rd_idx][COUNTER_W-1];
                    pr_target = pr_taken ? target_mem[rd_idx] : 32'd0;
                end
                KIND_JMP, KIND_CALL: begin
                    pr_taken  = 1'b1;
                    pr_target = target_mem[rd_idx];
                end
                KIND_RET: begin
                    pr_taken  = !ras_empty;
                    pr_target = pr_taken ? ras_top : 32'd0;
                end
                default: begin
                    pr_taken  = 1'b0;
                    pr_target = 32'd0;
                end
            endcase
        end
    end

    // Control state: valid bits, counters and stack bookkeeping; reset beats invalidate beats update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid   <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_mem[i] <= '0;
        end else if (inv_all) begin
            valid   <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (up_valid) begin
            if (alloc) begin
                valid[up_idx]   <= 1'b1;
                ctr_mem[up_idx] <= CTR_WEAK;
            end else if (up_hit && is_br) begin
                ctr_mem[up_idx] <= ctr_next;
            end
            if (ras_push) begin
                ras_ptr <= ptr_inc;
                if (!ras_full)
                    ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (ras_pop) begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // Payload storage is left unreset; the valid bits and stack count hide stale contents.
    always_ff @(posedge CLK) begin
        if (alloc)
            tag_mem[up_idx] <= up_tag;
        if (wr_target)
            target_mem[up_idx] <= up_target;
        if (wr_kind)
            kind_mem[up_idx] <= kind_t'(up_kind);
        if (ras_push)
            ras_mem[ras_ptr] <= up_pc + 32'd4;
    end

endmodule
